// File: rtl/tx_sched_pkg.sv
// Shared types and default constants for the transmit scheduler.
package tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  // 50 MHz system clock divided down to 9600 baud
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  // Bit periods tolerated without a frame-complete indication
  localparam int DEFAULT_TIMEOUT_BITS = 12;

  // Width of the per-frame transmit_enable pulse counter
  localparam int PULSE_W = 4;

endpackage

// File: rtl/baud_tick.sv
// Baud-rate divider: flags the last clock of every bit period while enabled.
module baud_tick #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int BAUD_W       = 13
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [BAUD_W-1:0] LAST = BAUD_W'(CLKS_PER_BIT - 1);

  logic [BAUD_W-1:0] count;

  assign tick = enable && (count == LAST);

  // Count clocks within a bit period, wrapping to zero on the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/tx_scheduler.sv
// Shares the UART transmit path between two byte sources: round-robin grant,
// one-cycle load, then baud-paced transmit_enable until the frame completes.
module tx_scheduler
  import tx_sched_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int BAUD_W       = 13,
  parameter int TIMEOUT_BITS = DEFAULT_TIMEOUT_BITS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       req1,
  input  logic [7:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] tx_data,
  output logic       load,
  output logic       transmit_enable,
  input  logic       char_sent,
  output logic       busy,
  output logic       timeout_err
);

  localparam logic [PULSE_W-1:0] PULSE_LIMIT = PULSE_W'(TIMEOUT_BITS);

  state_t             state, state_nxt;
  logic               last_grant, last_grant_nxt;
  logic [PULSE_W-1:0] pulse_count, pulse_count_nxt;
  logic [7:0]         tx_data_nxt;
  logic               load_nxt, transmit_enable_nxt, ack0_nxt, ack1_nxt;
  logic               busy_nxt, timeout_err_nxt;
  logic               tick;
  logic               grant1;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .BAUD_W      (BAUD_W)
  ) u_baud_tick (
    .clk   (clk),
    .reset (reset),
    .clear (state != SEND),
    .enable(state == SEND),
    .tick  (tick)
  );

  // Source 1 wins when it is the only requester or when source 0 went last
  assign grant1 = req1 && (!req0 || (last_grant == 1'b0));

  // Next-state and next-output decode; every output is registered below
  always_comb begin
    state_nxt           = state;
    last_grant_nxt      = last_grant;
    pulse_count_nxt     = pulse_count;
    tx_data_nxt         = tx_data;
    timeout_err_nxt     = timeout_err;
    load_nxt            = 1'b0;
    transmit_enable_nxt = 1'b0;
    ack0_nxt            = 1'b0;
    ack1_nxt            = 1'b0;
    busy_nxt            = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt      = LOAD;
          load_nxt       = 1'b1;
          busy_nxt       = 1'b1;
          last_grant_nxt = grant1;
          if (grant1) begin
            tx_data_nxt = data1;
            ack1_nxt    = 1'b1;
          end else begin
            tx_data_nxt = data0;
            ack0_nxt    = 1'b1;
          end
        end
      end
      LOAD: begin
        state_nxt       = SEND;
        busy_nxt        = 1'b1;
        pulse_count_nxt = '0;
      end
      SEND: begin
        busy_nxt = 1'b1;
        if (char_sent) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else if (tick) begin
          if (pulse_count == PULSE_LIMIT) begin
            state_nxt       = IDLE;
            busy_nxt        = 1'b0;
            timeout_err_nxt = 1'b1;
          end else begin
            transmit_enable_nxt = 1'b1;
            pulse_count_nxt     = pulse_count + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, arbitration history, pulse count and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      pulse_count     <= '0;
      tx_data         <= '0;
      load            <= 1'b0;
      transmit_enable <= 1'b0;
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      busy            <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      state           <= state_nxt;
      last_grant      <= last_grant_nxt;
      pulse_count     <= pulse_count_nxt;
      tx_data         <= tx_data_nxt;
      load            <= load_nxt;
      transmit_enable <= transmit_enable_nxt;
      ack0            <= ack0_nxt;
      ack1            <= ack1_nxt;
      busy            <= busy_nxt;
      timeout_err     <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// Scoreboard bench for tx_scheduler with a bit_counter model on char_sent.
module tb_tx_scheduler;

  localparam int CLKS    = 4;
  localparam int TIMEOUT = 12;
  localparam int FRAME   = 10;

  typedef struct {
    int src;
    int data;
    int pulses;
    int terr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       char_sent = 1'b0;
  logic       ack0, ack1, load, transmit_enable, busy, timeout_err;
  logic [7:0] tx_data;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  bit   model_on = 1'b1;
  int   late = 0;

  tx_scheduler #(
    .CLKS_PER_BIT(CLKS),
    .BAUD_W      (13),
    .TIMEOUT_BITS(TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .data0          (data0),
    .req1           (req1),
    .data1          (data1),
    .ack0           (ack0),
    .ack1           (ack1),
    .tx_data        (tx_data),
    .load           (load),
    .transmit_enable(transmit_enable),
    .char_sent      (char_sent),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_exp(input int src, input int data, input int pulses, input int terr);
    exp_t e;
    e.src = src; e.data = data; e.pulses = pulses; e.terr = terr;
    sb.push_back(e);
  endtask

  // Raise a request with its byte and hold it until the matching ack
  task automatic apply_stimulus(input int src, input logic [7:0] data);
    bit got = 1'b0;
    if (src == 0) begin data0 = data; req0 = 1'b1; end
    else          begin data1 = data; req1 = 1'b1; end
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if ((src == 0 && ack0) || (src == 1 && ack1)) got = 1'b1;
    end
    if (src == 0) req0 = 1'b0; else req1 = 1'b0;
    if (!got) check_output("ack_wait", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) check_output("idle_wait", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // bit_counter model: char_sent after the 10th pulse, optionally delayed
  initial begin
    int cnt = 0;
    int since = 0;
    forever begin
      @(negedge clk);
      if (!reset || load) begin
        cnt = 0; since = 0;
      end else if (transmit_enable) begin
        cnt++;
      end else if (cnt >= FRAME) begin
        since++;
      end
      char_sent = model_on && reset && busy && (cnt >= FRAME) && (since >= late);
    end
  end

  // Monitor: grants against the scoreboard, pulse spacing, frame totals
  initial begin
    bit   prev_busy = 1'b0;
    bit   in_frame = 1'b0;
    bit   first = 1'b1;
    int   gap = 0;
    int   pulses = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0; in_frame = 1'b0; first = 1'b1; gap = 0; pulses = 0;
      end else begin
        if (ack0 || ack1) begin
          check_output("ack_single", int'(ack0 && ack1), 0);
          if (sb.size() == 0) begin
            check_output("unexpected_ack", 1, 0);
          end else begin
            e = sb[0];
            check_output("grant_src", ack1 ? 1 : 0, e.src);
            check_output("tx_data", int'(tx_data), e.data);
            check_output("load_with_ack", int'(load), 1);
            check_output("busy_with_ack", int'(busy), 1);
          end
          in_frame = 1'b1; first = 1'b1; pulses = 0;
        end
        if (load) gap = 0; else gap++;
        if (transmit_enable) begin
          check_output(first ? "first_pulse_gap" : "pulse_gap", gap, first ? CLKS + 1 : CLKS);
          first = 1'b0; gap = 0; pulses++;
        end
        if (prev_busy && !busy && in_frame) begin
          in_frame = 1'b0;
          if (sb.size() == 0) begin
            check_output("unexpected_frame_end", 1, 0);
          end else begin
            e = sb.pop_front();
            check_output("pulse_count", pulses, e.pulses);
            check_output("timeout_err", int'(timeout_err), e.terr);
          end
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_output("rst_tx_data", int'(tx_data), 0);
    check_output("rst_load", int'(load), 0);
    check_output("rst_te", int'(transmit_enable), 0);
    check_output("rst_ack", int'({ack1, ack0}), 0);
    check_output("rst_busy", int'(busy), 0);
    check_output("rst_terr", int'(timeout_err), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Tie after reset: 0 first, then 1, then 0 again (never 0 twice in a row)
    push_exp(0, 8'h5A, FRAME, 0);
    push_exp(1, 8'h3C, FRAME, 0);
    push_exp(0, 8'hC3, FRAME, 0);
    fork
      begin apply_stimulus(0, 8'h5A); apply_stimulus(0, 8'hC3); end
      apply_stimulus(1, 8'h3C);
    join
    wait_idle();

    // Single request
    push_exp(0, 8'hA5, FRAME, 0);
    apply_stimulus(0, 8'hA5);
    wait_idle();

    // Request from source 1 held during source 0's frame
    push_exp(0, 8'h11, FRAME, 0);
    push_exp(1, 8'h22, FRAME, 0);
    fork
      apply_stimulus(0, 8'h11);
      begin
        repeat (10) @(negedge clk);
        fork
          apply_stimulus(1, 8'h22);
          begin
            bit fell = 1'b0;
            for (int i = 0; i < 200 && !fell; i++) begin
              @(negedge clk);
              if (!busy) fell = 1'b1;
            end
            check_output("held_frame_end", int'(fell), 1);
            check_output("held_idle_gap", int'(ack1), 0);
            @(negedge clk);
            check_output("held_ack1", int'(ack1), 1);
          end
        join
      end
    join
    wait_idle();

    // char_sent coinciding with a baud wrap
    late = 3;
    push_exp(1, 8'hE7, FRAME, 0);
    apply_stimulus(1, 8'hE7);
    wait_idle();
    late = 0;

    // Timeout, then normal service with the flag still set
    model_on = 1'b0;
    push_exp(1, 8'h99, TIMEOUT, 1);
    apply_stimulus(1, 8'h99);
    wait_idle();
    model_on = 1'b1;
    push_exp(0, 8'h42, FRAME, 1);
    apply_stimulus(0, 8'h42);
    wait_idle();

    // Asynchronous reset mid-frame
    push_exp(0, 8'h77, FRAME, 1);
    apply_stimulus(0, 8'h77);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    #1;
    check_output("async_tx_data", int'(tx_data), 0);
    check_output("async_te", int'(transmit_enable), 0);
    check_output("async_busy", int'(busy), 0);
    check_output("async_terr", int'(timeout_err), 0);
    check_output("async_load_ack", int'({load, ack1, ack0}), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Tie after release grants source 0 first
    push_exp(0, 8'h81, FRAME, 0);
    push_exp(1, 8'h18, FRAME, 0);
    fork
      apply_stimulus(0, 8'h81);
      apply_stimulus(1, 8'h18);
    join
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
